// File: rtl/calc_sequencer.sv
// Two-operand calculator sequencer: operand entry, latch, add/sub/mul/div compute, result hold.
// Latency: add/sub DONE three cycles after the btn_next that leaves ENTER_B; mul/div take 2+ITER cycles.
// Backpressure: none; btn_next is ignored while busy, and btn_clear aborts from any state.
module calc_sequencer #(
    parameter int MAX_VALUE = 9999,
    parameter int ITER      = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_clear,
    input  logic [1:0]  op_sel,
    input  logic [13:0] number_1,
    input  logic [13:0] number_2,
    output logic        write_number_select,
    output logic        clear_numbers,
    output logic        busy,
    output logic [13:0] result,
    output logic        result_valid,
    output logic        error
);

    localparam int          CNT_W = $clog2(ITER + 1);
    localparam logic [27:0] MAX_W = 28'(MAX_VALUE);
    localparam logic [1:0]  OP_ADD = 2'd0;
    localparam logic [1:0]  OP_SUB = 2'd1;
    localparam logic [1:0]  OP_MUL = 2'd2;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        LATCH   = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Latched operands and the error flag known at latch time (range or divide-by-zero).
    logic [13:0]      op_a, op_b;
    logic [1:0]       op_q;
    logic             err_pre;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    // Iterative datapath registers: shift-add multiplier and restoring divider.
    logic [27:0] prod, mcand;
    logic [13:0] mplier;
    logic [13:0] rem, quot;

    logic        clear_req;
    logic        compute_last;
    logic [14:0] sum;
    logic [27:0] mul_next;
    logic [14:0] rem_shift;
    logic        div_ge;
    logic [13:0] rem_next, quot_next;
    logic        fail;
    logic [13:0] value;

    // One-step combinational views of the iterative datapath and the final outcome.
    always_comb begin
        sum          = {1'b0, op_a} + {1'b0, op_b};
        mul_next     = prod + (mplier[0] ? mcand : 28'd0);
        rem_shift    = {rem, quot[13]};
        div_ge       = rem_shift >= {1'b0, op_b};
        rem_next     = div_ge ? 14'(rem_shift - {1'b0, op_b}) : rem_shift[13:0];
        quot_next    = {quot[12:0], div_ge};
        compute_last = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt == CNT_W'(ITER - 1));
        fail         = err_pre;
        value        = quot_next;
        case (op_q)
            OP_ADD: begin
                fail  = err_pre || ({13'd0, sum} > MAX_W);
                value = sum[13:0];
            end
            OP_SUB: begin
                fail  = err_pre || (op_a < op_b);
                value = op_a - op_b;
            end
            OP_MUL: begin
                fail  = err_pre || (mul_next > MAX_W);
                value = mul_next[13:0];
            end
            default: begin
                fail  = err_pre;
                value = quot_next;
            end
        endcase
    end

    // State register; clear_numbers is registered and self-suppressing so it never repeats back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ENTER_A;
            clear_numbers <= 1'b0;
        end else begin
            state         <= state_nxt;
            clear_numbers <= clear_req && !clear_numbers;
        end
    end

    // Next-state logic; btn_clear overrides everything, btn_next only matters in entry and DONE states.
    always_comb begin
        state_nxt = state;
        if (btn_clear) begin
            state_nxt = ENTER_A;
        end else begin
            case (state)
                ENTER_A: if (btn_next) state_nxt = ENTER_B;
                ENTER_B: if (btn_next) state_nxt = LATCH;
                LATCH:   state_nxt = COMPUTE;
                COMPUTE: if (compute_last) state_nxt = DONE;
                DONE:    if (btn_next) state_nxt = ENTER_A;
                default: state_nxt = ENTER_A;
            endcase
        end
    end

    // Output decode from the current state and the latched error flag.
    always_comb begin
        write_number_select = (state != ENTER_A);
        busy                = (state == LATCH) || (state == COMPUTE);
        result_valid        = (state == DONE) && !err_q;
        error               = (state == DONE) && err_q;
        clear_req           = btn_clear || ((state == DONE) && btn_next);
    end

    // Operand capture, iteration stepping and result/error update at the end of COMPUTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_q    <= '0;
            err_pre <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
            result  <= '0;
        end else if (btn_clear) begin
            err_q   <= 1'b0;
            err_pre <= 1'b0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            case (state)
                LATCH: begin
                    op_a    <= number_1;
                    op_b    <= number_2;
                    op_q    <= op_sel;
                    err_pre <= ({14'd0, number_1} > MAX_W) || ({14'd0, number_2} > MAX_W) ||
                               ((op_sel == 2'd3) && (number_2 == 14'd0));
                    cnt     <= '0;
                    prod    <= '0;
                    mcand   <= {14'd0, number_1};
                    mplier  <= number_2;
                    rem     <= '0;
                    quot    <= number_1;
                end
                COMPUTE: begin
                    cnt    <= cnt + CNT_W'(1);
                    prod   <= mul_next;
                    mcand  <= {mcand[26:0], 1'b0};
                    mplier <= {1'b0, mplier[13:1]};
                    rem    <= rem_next;
                    quot   <= quot_next;
                    if (compute_last) begin
                        err_q  <= fail;
                        result <= fail ? 14'd0 : value;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: vector table for all operations plus hand-written corner sequences.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
// Every wait on DUT completion is bounded and an expired bound counts as a failed check.
module tb_calc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        btn_next;
    logic        btn_clear;
    logic [1:0]  op_sel;
    logic [13:0] number_1;
    logic [13:0] number_2;
    logic        write_number_select;
    logic        clear_numbers;
    logic        busy;
    logic [13:0] result;
    logic        result_valid;
    logic        error;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [1:0]  op;
        logic [13:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    calc_sequencer #(.MAX_VALUE(9999), .ITER(14)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .btn_next            (btn_next),
        .btn_clear           (btn_clear),
        .op_sel              (op_sel),
        .number_1            (number_1),
        .number_2            (number_2),
        .write_number_select (write_number_select),
        .clear_numbers       (clear_numbers),
        .busy                (busy),
        .result              (result),
        .result_valid        (result_valid),
        .error               (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Called on a falling edge; holds btn_next for one rising edge, returns on the next falling edge.
    task automatic pulse_next();
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
    endtask

    task automatic pulse_clear();
        btn_clear = 1'b1;
        @(negedge clk);
        btn_clear = 1'b0;
    endtask

    // From ENTER_A, enters both operands and leaves the bench in the LATCH cycle (t+1).
    task automatic go_to_latch(input logic [13:0] a, input logic [13:0] b, input logic [1:0] op);
        number_1 = a;
        number_2 = b;
        op_sel   = op;
        check("enter_a_select", int'(write_number_select), 0);
        pulse_next();
        check("enter_b_select", int'(write_number_select), 1);
        pulse_next();
        check("latch_busy", int'(busy), 1);
    endtask

    // Counts cycles from t+1 until DONE is visible; scrambles inputs after the latch edge.
    task automatic wait_done(input int start, input logic [13:0] a, input logic [13:0] b,
                             output int lat);
        int n;
        n = start;
        while (!(result_valid || error) && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                number_1 = ~a;
                number_2 = ~b;
                op_sel   = op_sel ^ 2'd1;
            end
        end
        lat = n;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        go_to_latch(v.a, v.b, v.op);
        wait_done(1, v.a, v.b, lat);
        check("latency", lat, v.lat);
        check("result", int'(result), int'(v.res));
        check("error", int'(error), int'(v.err));
        check("result_valid", int'(result_valid), int'(!v.err));
        check("done_busy", int'(busy), 0);
        check("done_select", int'(write_number_select), 1);
        pulse_next();
        check("done_next_clear_pulse", int'(clear_numbers), 1);
        check("done_next_enter_a", int'(write_number_select), 0);
        @(negedge clk);
        check("clear_pulse_end", int'(clear_numbers), 0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{14'd123,   14'd456,   2'd0, 14'd579,  1'b0, 3};
        vecs[1]  = '{14'd9999,  14'd1,     2'd0, 14'd0,    1'b1, 3};
        vecs[2]  = '{14'd5000,  14'd4999,  2'd0, 14'd9999, 1'b0, 3};
        vecs[3]  = '{14'd10000, 14'd0,     2'd0, 14'd0,    1'b1, 3};
        vecs[4]  = '{14'd500,   14'd200,   2'd1, 14'd300,  1'b0, 3};
        vecs[5]  = '{14'd5,     14'd6,     2'd1, 14'd0,    1'b1, 3};
        vecs[6]  = '{14'd9999,  14'd9999,  2'd1, 14'd0,    1'b0, 3};
        vecs[7]  = '{14'd25,    14'd40,    2'd2, 14'd1000, 1'b0, 16};
        vecs[8]  = '{14'd100,   14'd100,   2'd2, 14'd0,    1'b1, 16};
        vecs[9]  = '{14'd99,    14'd101,   2'd2, 14'd9999, 1'b0, 16};
        vecs[10] = '{14'd200,   14'd200,   2'd2, 14'd0,    1'b1, 16};
        vecs[11] = '{14'd7,     14'd2,     2'd3, 14'd3,    1'b0, 16};
        vecs[12] = '{14'd100,   14'd0,     2'd3, 14'd0,    1'b1, 16};
        vecs[13] = '{14'd9999,  14'd3,     2'd3, 14'd3333, 1'b0, 16};

        rst_n     = 1'b0;
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        op_sel    = 2'd0;
        number_1  = 14'd0;
        number_2  = 14'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_select", int'(write_number_select), 0);
        check("rst_clear_numbers", int'(clear_numbers), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_error", int'(error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // btn_next pulses during COMPUTE are ignored; mul still finishes at t+16.
        go_to_latch(14'd25, 14'd40, 2'd2);
        repeat (3) begin
            @(negedge clk);
            btn_next = 1'b1;
            @(negedge clk);
            btn_next = 1'b0;
        end
        wait_done(7, 14'd25, 14'd40, lat);
        check("ignore_next_latency", lat, 16);
        check("ignore_next_result", int'(result), 1000);
        check("ignore_next_valid", int'(result_valid), 1);

        // btn_clear in DONE zeroes the result and returns to ENTER_A.
        pulse_clear();
        check("clear_done_result", int'(result), 0);
        check("clear_done_valid", int'(result_valid), 0);
        check("clear_done_select", int'(write_number_select), 0);
        check("clear_done_pulse", int'(clear_numbers), 1);
        @(negedge clk);

        // Reset in the 5th COMPUTE cycle of a multiply aborts everything.
        go_to_latch(14'd25, 14'd40, 2'd2);
        repeat (5) @(negedge clk);
        check("mid_busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_select", int'(write_number_select), 0);
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_valid", int'(result_valid), 0);
        check("mid_rst_error", int'(error), 0);
        check("mid_rst_clear_numbers", int'(clear_numbers), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_wait_select", int'(write_number_select), 0);
        check("post_rst_wait_valid", int'(result_valid), 0);
        check("post_rst_wait_busy", int'(busy), 0);
        pulse_next();
        check("post_rst_first_next", int'(write_number_select), 1);

        // btn_clear and btn_next together in ENTER_B: clear wins, no LATCH.
        btn_clear = 1'b1;
        btn_next  = 1'b1;
        @(negedge clk);
        btn_clear = 1'b0;
        btn_next  = 1'b0;
        check("both_select", int'(write_number_select), 0);
        check("both_busy", int'(busy), 0);
        check("both_clear_pulse", int'(clear_numbers), 1);
        @(negedge clk);
        check("both_clear_end", int'(clear_numbers), 0);
        check("both_no_latch", int'(busy), 0);

        // btn_clear mid-divide discards the computation.
        go_to_latch(14'd100, 14'd5, 2'd3);
        repeat (4) @(negedge clk);
        pulse_clear();
        check("abort_div_busy", int'(busy), 0);
        check("abort_div_select", int'(write_number_select), 0);
        check("abort_div_result", int'(result), 0);
        repeat (20) @(negedge clk);
        check("abort_div_no_done", int'(result_valid), 0);
        check("abort_div_no_error", int'(error), 0);

        // btn_clear held two cycles: clear_numbers must not stay high twice in a row.
        btn_clear = 1'b1;
        @(negedge clk);
        check("dbl_clear_first", int'(clear_numbers), 1);
        @(negedge clk);
        btn_clear = 1'b0;
        check("dbl_clear_second", int'(clear_numbers), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
